proc_host_ctrl: RTL and testbench

PROC_HOST_CTRL -- requirements
Module: proc_host_ctrl

---
 rtl/proc_host_pkg.sv | 21 ++
 rtl/proc_host_out_reg.sv | 44 ++++
 rtl/proc_host_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_proc_host_ctrl.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_host_pkg.sv
// Shared constants and state encoding for the processor host controller.
// Imported by the controller top and its output register.
package proc_host_pkg;

    localparam int PH_DATA_WIDTH   = 32;
    localparam int PH_ADDR_WIDTH   = 10;
    localparam int PH_OP_WIDTH     = 3;
    localparam int PH_DEPTH        = 1 << PH_ADDR_WIDTH;
    localparam int PH_DONE_TIMEOUT = 4096;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        RUN,
        READ_REQ,
        READ_CAP,
        READ_OUT
    } state_t;

endpackage

// File: rtl/proc_host_out_reg.sv
// Result output register: captures one word, then holds data and valid
// steady until the consumer accepts it.
module proc_host_out_reg
    import proc_host_pkg::*;
#(
    parameter int DATA_WIDTH = PH_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  capture_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (capture_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/proc_host_ctrl.sv
// Host-side batch controller: streams DEPTH operand tuples into processor
// memory, starts a run, waits for done, then streams the results back out.
module proc_host_ctrl
    import proc_host_pkg::*;
#(
    parameter int DATA_WIDTH   = PH_DATA_WIDTH,
    parameter int ADDR_WIDTH   = PH_ADDR_WIDTH,
    parameter int OP_WIDTH     = PH_OP_WIDTH,
    parameter int DEPTH        = 2 ** ADDR_WIDTH,
    parameter int DONE_TIMEOUT = PH_DONE_TIMEOUT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_a,
    input  logic [DATA_WIDTH-1:0] s_b,
    input  logic [OP_WIDTH-1:0]   s_op,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [ADDR_WIDTH-1:0] addr_data_o,
    output logic                  ena_data_a_o,
    output logic                  wea_data_a_o,
    output logic                  ena_data_b_o,
    output logic                  wea_data_b_o,
    output logic                  ena_data_result_o,
    output logic                  wea_data_result_o,
    output logic [OP_WIDTH-1:0]   op_o,
    output logic [ADDR_WIDTH-1:0] addr_op_o,
    output logic                  ena_op_o,
    output logic                  wea_op_o,
    input  logic [DATA_WIDTH-1:0] result_i,
    output logic                  start_o,
    input  logic                  done_i,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int                    WD_W    = $clog2(DONE_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] K_LAST  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [WD_W-1:0]       WD_LAST = WD_W'(DONE_TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] k_q, k_d;
    logic [WD_W-1:0]       wdog_q, wdog_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_data_q, addr_data_d;
    logic [ADDR_WIDTH-1:0] addr_op_q, addr_op_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic                  wr_a_q, wr_a_d, wr_b_q, wr_b_d, wr_op_q, wr_op_d;
    logic                  rd_res_q, rd_res_d;
    logic                  s_ready_q, s_ready_d;
    logic                  start_q, start_d, busy_q, busy_d, err_q, err_d;

    // Memory strobes are registered, so each write lands one cycle after the
    // state that decided it; this keeps A/op and B writes in separate cycles.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        wdog_d      = wdog_q;
        b_d         = b_q;
        data_d      = data_q;
        addr_data_d = addr_data_q;
        addr_op_d   = addr_op_q;
        op_d        = op_q;
        wr_a_d      = 1'b0;
        wr_b_d      = 1'b0;
        wr_op_d     = 1'b0;
        rd_res_d    = 1'b0;
        start_d     = start_q;
        err_d       = err_q;
        unique case (state_q)
            IDLE: begin
                if (!done_i) begin
                    k_d     = '0;
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                if (s_valid && s_ready_q) begin
                    data_d      = s_a;
                    op_d        = s_op;
                    addr_data_d = k_q;
                    addr_op_d   = k_q;
                    wr_a_d      = 1'b1;
                    wr_op_d     = 1'b1;
                    b_d         = s_b;
                    state_d     = LOAD_B;
                end
            end
            LOAD_B: begin
                data_d      = b_q;
                addr_data_d = k_q;
                wr_b_d      = 1'b1;
                if (k_q == K_LAST) begin
                    wdog_d  = '0;
                    start_d = 1'b1;
                    state_d = RUN;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = LOAD_A;
                end
            end
            RUN: begin
                if (done_i) begin
                    start_d     = 1'b0;
                    k_d         = '0;
                    addr_data_d = '0;
                    rd_res_d    = 1'b1;
                    state_d     = READ_REQ;
                end else if (wdog_q == WD_LAST) begin
                    err_d   = 1'b1;
                    start_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            READ_REQ: state_d = READ_CAP;
            READ_CAP: state_d = READ_OUT;
            READ_OUT: begin
                if (m_valid && m_ready) begin
                    if (k_q == K_LAST) begin
                        state_d = IDLE;
                    end else begin
                        k_d         = k_q + 1'b1;
                        addr_data_d = k_q + 1'b1;
                        rd_res_d    = 1'b1;
                        state_d     = READ_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        s_ready_d = (state_d == LOAD_A);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            k_q         <= '0;
            wdog_q      <= '0;
            b_q         <= '0;
            data_q      <= '0;
            addr_data_q <= '0;
            addr_op_q   <= '0;
            op_q        <= '0;
            wr_a_q      <= 1'b0;
            wr_b_q      <= 1'b0;
            wr_op_q     <= 1'b0;
            rd_res_q    <= 1'b0;
            s_ready_q   <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wdog_q      <= wdog_d;
            b_q         <= b_d;
            data_q      <= data_d;
            addr_data_q <= addr_data_d;
            addr_op_q   <= addr_op_d;
            op_q        <= op_d;
            wr_a_q      <= wr_a_d;
            wr_b_q      <= wr_b_d;
            wr_op_q     <= wr_op_d;
            rd_res_q    <= rd_res_d;
            s_ready_q   <= s_ready_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    proc_host_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk_i    (CLK),
        .rst_i    (RST),
        .capture_i(state_q == READ_CAP),
        .data_i   (result_i),
        .ready_i  (m_ready),
        .valid_o  (m_valid),
        .data_o   (m_data)
    );

    assign s_ready           = s_ready_q;
    assign data_o            = data_q;
    assign addr_data_o       = addr_data_q;
    assign addr_op_o         = addr_op_q;
    assign op_o              = op_q;
    assign ena_data_a_o      = wr_a_q;
    assign wea_data_a_o      = wr_a_q;
    assign ena_data_b_o      = wr_b_q;
    assign wea_data_b_o      = wr_b_q;
    assign ena_op_o          = wr_op_q;
    assign wea_op_o          = wr_op_q;
    assign ena_data_result_o = rd_res_q;
    assign wea_data_result_o = 1'b0;
    assign start_o           = start_q;
    assign busy_o            = busy_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_proc_host_ctrl.sv
// Scoreboard bench for proc_host_ctrl: a behavioural processor (memories,
// done timing, result function) plus queues of expected writes and results.
module tb_proc_host_ctrl;

    localparam int DW           = 32;
    localparam int AW           = 10;
    localparam int OW           = 3;
    localparam int DEPTH        = 1 << AW;
    localparam int DONE_TIMEOUT = 4096;
    localparam int DONE_LAT     = 1100;

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_a = '0;
    logic [DW-1:0] s_b = '0;
    logic [OW-1:0] s_op = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [DW-1:0] data_o;
    logic [AW-1:0] addr_data_o;
    logic          ena_data_a_o, wea_data_a_o, ena_data_b_o, wea_data_b_o;
    logic          ena_data_result_o, wea_data_result_o;
    logic [OW-1:0] op_o;
    logic [AW-1:0] addr_op_o;
    logic          ena_op_o, wea_op_o;
    logic [DW-1:0] result_i = '0;
    logic          start_o;
    logic          done_i = 1'b0;
    logic          busy_o;
    logic          err_o;

    int            tests = 0;
    int            fails = 0;
    int            hsCount = 0;
    int            rdIdx = 0;
    int            wrCountA = 0, wrCountB = 0, wrCountOp = 0;
    int            startCnt = 0;
    int            rdAddr;
    bit            doneEnable = 1'b1;
    bit            forceDone = 1'b0;
    wr_t           expA[$], expB[$], expOp[$];
    logic [DW-1:0] expRes[$];
    logic [DW-1:0] resMem[DEPTH];

    bit            monWrA, monWrB, monWrOp, monRd, monAny;
    wr_t           monE;
    logic [DW-1:0] monR;

    proc_host_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .OP_WIDTH    (OW),
        .DEPTH       (DEPTH),
        .DONE_TIMEOUT(DONE_TIMEOUT)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_a              (s_a),
        .s_b              (s_b),
        .s_op             (s_op),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .data_o           (data_o),
        .addr_data_o      (addr_data_o),
        .ena_data_a_o     (ena_data_a_o),
        .wea_data_a_o     (wea_data_a_o),
        .ena_data_b_o     (ena_data_b_o),
        .wea_data_b_o     (wea_data_b_o),
        .ena_data_result_o(ena_data_result_o),
        .wea_data_result_o(wea_data_result_o),
        .op_o             (op_o),
        .addr_op_o        (addr_op_o),
        .ena_op_o         (ena_op_o),
        .wea_op_o         (wea_op_o),
        .result_i         (result_i),
        .start_o          (start_o),
        .done_i           (done_i),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportMissing(input string name, input string what);
        tests++;
        fails++;
        $display("[TB] FAIL %s: got %s, required none", name, what);
    endtask

    // What the processor would compute for a tuple; doubles as result memory content.
    function automatic logic [DW-1:0] procModel(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic [OW-1:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    // Processor done: rises DONE_LAT cycles into a run, drops once start_o falls.
    always @(negedge CLK) begin
        if (forceDone) begin
            done_i = 1'b1;
        end else if (start_o && doneEnable) begin
            startCnt = startCnt + 1;
            done_i   = (startCnt >= DONE_LAT);
        end else begin
            startCnt = 0;
            done_i   = 1'b0;
        end
    end

    // Result memory with one cycle of read latency.
    always @(posedge CLK) begin
        if (ena_data_result_o && !wea_data_result_o) begin
            rdAddr = int'(addr_data_o);
            #1 result_i = resMem[rdAddr];
        end
    end

    // Monitor: every strobe or result handshake pops and checks the scoreboard.
    always @(negedge CLK) begin
        if (!RST) begin
            monWrA  = ena_data_a_o;
            monWrB  = ena_data_b_o;
            monWrOp = ena_op_o;
            monRd   = ena_data_result_o;
            monAny  = monWrA || monWrB || monWrOp || monRd || wea_data_result_o;
            if (monAny) begin
                checkOutput("strobeRules",
                            64'({ena_data_a_o == wea_data_a_o, ena_data_b_o == wea_data_b_o,
                                 ena_op_o == wea_op_o, !wea_data_result_o, monWrA == monWrOp,
                                 (int'(monWrA) + int'(monWrB) + int'(monRd)) <= 1}),
                            64'h3F);
            end
            if (monWrA) begin
                wrCountA++;
                if (expA.size() == 0) reportMissing("writeA", "unexpected write");
                else begin
                    monE = expA.pop_front();
                    checkOutput("writeA.addr", 64'(addr_data_o), 64'(monE.addr));
                    checkOutput("writeA.data", 64'(data_o), 64'(monE.data));
                end
            end
            if (monWrOp) begin
                wrCountOp++;
                if (expOp.size() == 0) reportMissing("writeOp", "unexpected write");
                else begin
                    monE = expOp.pop_front();
                    checkOutput("writeOp.addr", 64'(addr_op_o), 64'(monE.addr));
                    checkOutput("writeOp.data", 64'(op_o), 64'(monE.data));
                end
            end
            if (monWrB) begin
                wrCountB++;
                if (expB.size() == 0) reportMissing("writeB", "unexpected write");
                else begin
                    monE = expB.pop_front();
                    checkOutput("writeB.addr", 64'(addr_data_o), 64'(monE.addr));
                    checkOutput("writeB.data", 64'(data_o), 64'(monE.data));
                end
            end
            if (monRd) begin
                checkOutput("readAddr", 64'(addr_data_o), 64'(rdIdx));
                rdIdx++;
            end
            if (m_valid && m_ready) begin
                hsCount++;
                if (expRes.size() == 0) reportMissing("result", "unexpected handshake");
                else begin
                    monR = expRes.pop_front();
                    checkOutput("result.data", 64'(m_data), 64'(monR));
                end
            end
        end
    end

    task automatic clearModel();
        expA.delete();
        expB.delete();
        expOp.delete();
        expRes.delete();
        hsCount   = 0;
        rdIdx     = 0;
        wrCountA  = 0;
        wrCountB  = 0;
        wrCountOp = 0;
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, ".data"}, {m_data, data_o}, 64'h0);
        checkOutput({name, ".ctrl"},
                    64'({addr_data_o, addr_op_o, op_o, s_ready, m_valid, ena_data_a_o, wea_data_a_o,
                         ena_data_b_o, wea_data_b_o, ena_data_result_o, wea_data_result_o,
                         ena_op_o, wea_op_o, start_o, busy_o, err_o}),
                    64'h0);
    endtask

    // Feeds tuples first..first+count-1; randomMode picks random operands.
    task automatic applyStimulus(input int first, input int count, input bit randomMode);
        logic [DW-1:0] a, b;
        logic [OW-1:0] op;
        int            guard;
        bit            hs;
        for (int k = first; k < first + count; k++) begin
            if (randomMode) begin
                a  = $urandom;
                b  = $urandom;
                op = OW'($urandom_range(0, 7));
            end else begin
                a  = DW'(k);
                b  = DW'(2 * k);
                op = '0;
            end
            repeat ($urandom_range(0, 2)) begin
                s_valid = 1'b0;
                s_a     = $urandom;
                s_b     = $urandom;
                @(posedge CLK);
                #1;
            end
            expA.push_back('{k, a});
            expB.push_back('{k, b});
            expOp.push_back('{k, DW'(op)});
            resMem[k] = procModel(a, b, op);
            s_valid = 1'b1;
            s_a     = a;
            s_b     = b;
            s_op    = op;
            guard   = 0;
            hs      = 1'b0;
            while (!hs && guard < 50) begin
                @(negedge CLK);
                hs = s_ready;
                @(posedge CLK);
                #1;
                guard++;
            end
            if (!hs) begin
                reportMissing("tupleAccept", "no s_ready within 50 cycles");
                s_valid = 1'b0;
                return;
            end
            if ($urandom_range(0, 1) == 1) begin
                s_a = $urandom;
                s_b = $urandom;
                @(posedge CLK);
                #1;
            end
            s_valid = 1'b0;
        end
    endtask

    task automatic waitStart();
        int g = 0;
        bit seen = 1'b0;
        while (!seen && g < 20) begin
            @(negedge CLK);
            seen = start_o;
            g++;
        end
        checkOutput("startAfterLoad", 64'(seen), 64'h1);
    endtask

    task automatic checkLoadCounts();
        @(posedge CLK);
        #1;
        checkOutput("countA", 64'(wrCountA), 64'(DEPTH));
        checkOutput("countB", 64'(wrCountB), 64'(DEPTH));
        checkOutput("countOp", 64'(wrCountOp), 64'(DEPTH));
    endtask

    // Drives m_ready for one readback; stallWord >= 0 withholds ready for 20 cycles there.
    task automatic runReadback(input bit randomReady, input int stallWord);
        int guard = 0;
        int g;
        bit stallDone = (stallWord < 0);
        for (int k = 0; k < DEPTH; k++) expRes.push_back(resMem[k]);
        m_ready = 1'b1;
        while (hsCount < DEPTH && guard < 30000) begin
            @(posedge CLK);
            #1;
            guard++;
            if (!stallDone && hsCount == stallWord) begin
                stallDone = 1'b1;
                m_ready   = 1'b0;
                g         = 0;
                while (!m_valid && g < 10) begin
                    @(negedge CLK);
                    g++;
                end
                for (int c = 0; c < 20; c++) begin
                    checkOutput("stall.data", 64'(m_data), 64'(resMem[stallWord]));
                    checkOutput("stall.valid", 64'(m_valid), 64'h1);
                    checkOutput("stall.addr", 64'(addr_data_o), 64'(stallWord));
                    @(negedge CLK);
                end
                checkOutput("stall.handshakes", 64'(hsCount), 64'(stallWord));
                @(posedge CLK);
                #1;
                m_ready = 1'b1;
            end else if (randomReady) begin
                m_ready = 1'($urandom_range(0, 1));
            end else begin
                m_ready = 1'b1;
            end
        end
        @(negedge CLK);
        checkOutput("handshakes", 64'(hsCount), 64'(DEPTH));
        checkOutput("idleAfterRead", 64'(busy_o), 64'h0);
        checkOutput("errClear", 64'(err_o), 64'h0);
        m_ready = 1'b0;
    endtask

    initial begin
        int g;
        int runCnt;
        forceDone = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkAllZero("resetState");
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Stale done at batch entry keeps the controller parked.
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            checkOutput("staleDone.s_ready", 64'({s_ready, busy_o}), 64'h0);
        end
        @(posedge CLK);
        #1;
        forceDone = 1'b0;
        g = 0;
        while (!s_ready && g < 6) begin
            @(negedge CLK);
            g++;
        end
        checkOutput("readyAfterDoneFalls", 64'(s_ready), 64'h1);

        // Batch 1: A=k, B=2k, ADD, result 3k, ready always high except the stall.
        clearModel();
        applyStimulus(0, DEPTH, 1'b0);
        waitStart();
        checkLoadCounts();
        runReadback(1'b0, 5);

        // Reset during tuple 300, then a fresh random batch from address 0.
        clearModel();
        applyStimulus(0, 300, 1'b1);
        g = 0;
        while (expB.size() != 0 && g < 10) begin
            @(posedge CLK);
            #1;
            g++;
        end
        s_valid = 1'b1;
        s_a     = $urandom;
        RST     = 1'b1;
        @(posedge CLK);
        #1;
        RST     = 1'b0;
        s_valid = 1'b0;
        @(negedge CLK);
        checkAllZero("resetMidLoad");
        clearModel();
        applyStimulus(0, DEPTH, 1'b1);
        waitStart();
        checkLoadCounts();
        runReadback(1'b1, -1);

        // Batch 3: done never comes, watchdog must fire.
        clearModel();
        doneEnable = 1'b0;
        applyStimulus(0, DEPTH, 1'b1);
        waitStart();
        runCnt = 1;
        while (runCnt < DONE_TIMEOUT + 20) begin
            @(negedge CLK);
            if (!start_o) break;
            runCnt++;
        end
        checkOutput("timeout.cycles", 64'(runCnt), 64'(DONE_TIMEOUT));
        checkOutput("timeout.err", 64'(err_o), 64'h1);
        checkOutput("timeout.start", 64'(start_o), 64'h0);
        checkOutput("timeout.idle", 64'(busy_o), 64'h0);
        repeat (5) @(negedge CLK);
        checkOutput("errSticky", 64'(err_o), 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
